// File: rtl/seq_divider_pkg.sv
// Shared definitions for the iterative restoring divider.
package seq_divider_pkg;

  // Default operand width; legal range is 2..16.
  localparam int DEF_WIDTH = 4;

  // Controller state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, then try the subtract.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   p,
  input  logic             dbit,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   p_next,
  output logic             qbit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The partial remainder is always below the divisor, so its top bit carries
  // no information into the shift.
  logic unused_p_msb;
  assign unused_p_msb = p[WIDTH];

  // Trial subtract; a set MSB is the borrow, meaning the divisor did not fit.
  always_comb begin
    shifted = {p[WIDTH-1:0], dbit};
    trial   = shifted - {1'b0, b};
    qbit    = ~trial[WIDTH];
    p_next  = trial[WIDTH] ? shifted : trial;
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, MSB first.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] bq;
  logic [WIDTH-1:0] d;
  logic [WIDTH:0]   p;
  logic [WIDTH:0]   p_nxt;
  logic             qbit;
  logic [WIDTH-1:0] d_nxt;

  div_step #(.WIDTH(WIDTH)) u_step (
    .p      (p),
    .dbit   (d[WIDTH-1]),
    .b      (bq),
    .p_next (p_nxt),
    .qbit   (qbit)
  );

  // Dividend register doubles as the quotient: shift left, new quotient bit in at the LSB.
  assign d_nxt = {d[WIDTH-2:0], qbit};

  // Controller, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bq          <= '0;
      d           <= '0;
      p           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_RUN: begin
          // start is ignored here; a request must wait for the done cycle.
          p <= p_nxt;
          d <= d_nxt;
          if (cnt == '0) begin
            state       <= ST_FIN;
            busy        <= 1'b0;
            done        <= 1'b1;
            Q           <= d_nxt;
            R           <= p_nxt[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          // IDLE and FIN both accept a request, giving back-to-back operation.
          if (start) begin
            bq <= B;
            d  <= A;
            p  <= '0;
            if (B == '0) begin
              // Zero divisor resolves immediately without entering RUN.
              state       <= ST_FIN;
              done        <= 1'b1;
              Q           <= '1;
              R           <= A;
              div_by_zero <= 1'b1;
            end else begin
              state <= ST_RUN;
              busy  <= 1'b1;
              cnt   <= CW'(WIDTH - 1);
            end
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
